// File: rtl/bcd_serial_alu.sv
// Purpose: multi-cycle BCD/binary ALU; add/sub/cmp one nibble per cycle LSB first, logic/shift in one step.
// Latency: result and done one rdy=1 edge after accept for logic/shift ops, DIGITS+1 edges for arithmetic.
// Backpressure: rdy=0 freezes every register; start is accepted only when idle (including the done cycle).
module bcd_serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rdy,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             bcd,
  input  logic [WIDTH-1:0] ai,
  input  logic [WIDTH-1:0] bi,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             v,
  output logic             z,
  output logic             n,
  output logic             hc
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ASL = 4'b0010;
  localparam logic [3:0] OP_ROL = 4'b0011;
  localparam logic [3:0] OP_LSR = 4'b0100;
  localparam logic [3:0] OP_ROR = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_ARITH, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             bcd_q, bcd_d;
  logic             ci_q, ci_d;
  logic [WIDTH-1:0] a_q, a_d;         // original A, kept for CMP output and logic/shift ops
  logic [WIDTH-1:0] a_sh_q, a_sh_d;   // A shifted right one nibble per arithmetic step
  logic [WIDTH-1:0] b_sh_q, b_sh_d;   // B (inverted for SUB/CMP), shifted like A
  logic [WIDTH-1:0] res_q, res_d;     // partial sum, filled from the top nibble downwards
  logic             c_q, c_d;         // running nibble carry
  logic             hcp_q, hcp_d;     // nibble-0 carry awaiting the result edge
  logic             vp_q, vp_d;       // overflow awaiting the result edge
  logic             done_q, done_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             co_q, co_d;
  logic             vf_q, vf_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             hcf_q, hcf_d;

  logic       op_arith, op_sub, q_sub;
  logic [3:0] na, nb, nsum;
  logic [4:0] s_raw;
  logic       ncarry;
  logic [WIDTH-1:0] r_res;
  logic       r_co, r_v, r_hc;

  assign op_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  assign op_sub   = (op == OP_SUB) || (op == OP_CMP);
  assign q_sub    = (op_q == OP_SUB) || (op_q == OP_CMP);

  // One nibble of add/subtract with optional decimal correction
  always_comb begin
    na     = a_sh_q[3:0];
    nb     = b_sh_q[3:0];
    s_raw  = {1'b0, na} + {1'b0, nb} + {4'd0, c_q};
    nsum   = s_raw[3:0];
    ncarry = s_raw[4];
    if (bcd_q && !q_sub) begin
      if (s_raw > 5'd9) begin
        nsum   = s_raw[3:0] + 4'd6;
        ncarry = 1'b1;
      end
    end else if (bcd_q && q_sub) begin
      if (!s_raw[4]) begin
        nsum   = s_raw[3:0] - 4'd6;
        ncarry = 1'b0;
      end
    end
  end

  // Final result and flag selection, used on the result edge
  always_comb begin
    r_res = a_q;
    r_co  = 1'b0;
    r_v   = 1'b0;
    r_hc  = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin r_res = res_q; r_co = c_q; r_v = vp_q; r_hc = hcp_q; end
      OP_CMP:         begin r_res = a_q;   r_co = c_q; r_v = vp_q; r_hc = hcp_q; end
      OP_ASL: begin r_res = {a_q[WIDTH-2:0], 1'b0}; r_co = a_q[WIDTH-1]; end
      OP_ROL: begin r_res = {a_q[WIDTH-2:0], ci_q}; r_co = a_q[WIDTH-1]; end
      OP_LSR: begin r_res = {1'b0, a_q[WIDTH-1:1]}; r_co = a_q[0]; end
      OP_ROR: begin r_res = {ci_q, a_q[WIDTH-1:1]}; r_co = a_q[0]; end
      OP_OR:  r_res = a_q | b_sh_q;
      OP_AND: r_res = a_q & b_sh_q;
      OP_XOR: r_res = a_q ^ b_sh_q;
      default: r_res = a_q;
    endcase
  end

  // Next-state, operand capture, nibble sequencing and result write
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    bcd_d   = bcd_q;
    ci_d    = ci_q;
    a_d     = a_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    c_d     = c_q;
    hcp_d   = hcp_q;
    vp_d    = vp_q;
    done_d  = 1'b0;
    out_d   = out_q;
    co_d    = co_q;
    vf_d    = vf_q;
    z_d     = z_q;
    n_d     = n_q;
    hcf_d   = hcf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          bcd_d   = bcd;
          ci_d    = ci;
          a_d     = ai;
          a_sh_d  = ai;
          b_sh_d  = op_sub ? ~bi : bi;
          c_d     = (op == OP_CMP) ? 1'b1 : ci;
          cnt_d   = '0;
          state_d = op_arith ? S_ARITH : S_FINISH;
        end
      end
      S_ARITH: begin
        a_sh_d = a_sh_q >> 4;
        b_sh_d = b_sh_q >> 4;
        res_d  = {nsum, res_q[WIDTH-1:4]};
        c_d    = ncarry;
        if (cnt_q == '0) hcp_d = ncarry;
        if (cnt_q == LAST) begin
          vp_d    = (na[3] == nb[3]) && (s_raw[3] != na[3]);
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        out_d   = r_res;
        co_d    = r_co;
        vf_d    = r_v;
        hcf_d   = r_hc;
        // CMP reports the difference, not the passed-through A
        if ((op_q == OP_ADD) || q_sub) begin
          n_d = res_q[WIDTH-1];
          z_d = (res_q == '0);
        end else begin
          n_d = r_res[WIDTH-1];
          z_d = (r_res == '0);
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and nibble counter, frozen while rdy is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand, partial-result and output registers, frozen while rdy is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= '0;
      bcd_q  <= 1'b0;
      ci_q   <= 1'b0;
      a_q    <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      res_q  <= '0;
      c_q    <= 1'b0;
      hcp_q  <= 1'b0;
      vp_q   <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
      co_q   <= 1'b0;
      vf_q   <= 1'b0;
      z_q    <= 1'b1;
      n_q    <= 1'b0;
      hcf_q  <= 1'b0;
    end else if (rdy) begin
      op_q   <= op_d;
      bcd_q  <= bcd_d;
      ci_q   <= ci_d;
      a_q    <= a_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      res_q  <= res_d;
      c_q    <= c_d;
      hcp_q  <= hcp_d;
      vp_q   <= vp_d;
      done_q <= done_d;
      out_q  <= out_d;
      co_q   <= co_d;
      vf_q   <= vf_d;
      z_q    <= z_d;
      n_q    <= n_d;
      hcf_q  <= hcf_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign out  = out_q;
  assign co   = co_q;
  assign v    = vf_q;
  assign z    = z_q;
  assign n    = n_q;
  assign hc   = hcf_q;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Directed bench for bcd_serial_alu at WIDTH=8 and WIDTH=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Flags are compared as a packed {co, v, n, z, hc} vector.
module tb_bcd_serial_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, rdy;

  logic       start8, bcd8, ci8, busy8, done8, co8, v8, z8, n8, hc8;
  logic [3:0] op8;
  logic [7:0] ai8, bi8, out8;

  logic        start16, bcd16, ci16, busy16, done16, co16, v16, z16, n16, hc16;
  logic [3:0]  op16;
  logic [15:0] ai16, bi16, out16;

  int vecs = 0;
  int errs = 0;

  bcd_serial_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .rdy(rdy), .start(start8), .op(op8), .bcd(bcd8),
    .ai(ai8), .bi(bi8), .ci(ci8), .busy(busy8), .done(done8), .out(out8),
    .co(co8), .v(v8), .z(z8), .n(n8), .hc(hc8)
  );

  bcd_serial_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .rdy(rdy), .start(start16), .op(op16), .bcd(bcd16),
    .ai(ai16), .bi(bi16), .ci(ci16), .busy(busy16), .done(done16), .out(out16),
    .co(co16), .v(v16), .z(z16), .n(n16), .hc(hc16)
  );

  wire [4:0] flags8  = {co8, v8, n8, z8, hc8};
  wire [4:0] flags16 = {co16, v16, n16, z16, hc16};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and clock the accepting edge E0
  task automatic launch8(input logic [3:0] o, input logic b, input logic [7:0] a,
                         input logic [7:0] bb, input logic c);
    op8 = o; bcd8 = b; ai8 = a; bi8 = bb; ci8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  task automatic launch16(input logic [3:0] o, input logic b, input logic [15:0] a,
                          input logic [15:0] bb, input logic c);
    op16 = o; bcd16 = b; ai16 = a; bi16 = bb; ci16 = c; start16 = 1'b1;
    tick();
    start16 = 1'b0;
  endtask

  // Count edges after E0 until done, bounded
  task automatic wait8(output int lat);
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin tick(); lat++; end
  endtask

  task automatic wait16(output int lat);
    lat = 0;
    while (done16 !== 1'b1 && lat < 40) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rdy = 1'b1;
    #12;
    vecs++; if ({busy8, done8} !== 2'b00) begin errs++; $display("FAIL reset busy/done8: got %b want 00", {busy8, done8}); end
    vecs++; if (out8 !== 8'h00) begin errs++; $display("FAIL reset out8: got %h want 00", out8); end
    vecs++; if (flags8 !== 5'b00010) begin errs++; $display("FAIL reset flags8: got %b want 00010", flags8); end
    vecs++; if ({busy16, done16, out16, flags16} !== {2'b00, 16'h0000, 5'b00010}) begin
      errs++; $display("FAIL reset dut16: got %b %h %b want 00 0000 00010", {busy16, done16}, out16, flags16); end
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_add_bin();
    launch8(4'b0000, 1'b0, 8'h7F, 8'h01, 1'b0);
    vecs++; if ({busy8, done8} !== 2'b10) begin errs++; $display("FAIL add_bin after E0: got %b want 10", {busy8, done8}); end
    tick();
    vecs++; if ({busy8, done8} !== 2'b10) begin errs++; $display("FAIL add_bin after E1: got %b want 10", {busy8, done8}); end
    tick();
    vecs++; if ({busy8, done8} !== 2'b10) begin errs++; $display("FAIL add_bin after E2: got %b want 10", {busy8, done8}); end
    tick();
    vecs++; if ({busy8, done8} !== 2'b01) begin errs++; $display("FAIL add_bin after E3: got %b want 01", {busy8, done8}); end
    vecs++; if (out8 !== 8'h80) begin errs++; $display("FAIL add_bin out: got %h want 80", out8); end
    vecs++; if (flags8 !== 5'b01101) begin errs++; $display("FAIL add_bin flags: got %b want 01101", flags8); end
    tick(); tick();
    vecs++; if ({done8, out8} !== {1'b0, 8'h80}) begin errs++; $display("FAIL add_bin hold: got %b %h want 0 80", done8, out8); end
  endtask

  task automatic test_add_bcd();
    int lat;
    launch8(4'b0000, 1'b1, 8'h58, 8'h46, 1'b1);
    wait8(lat);
    vecs++; if (lat !== 3) begin errs++; $display("FAIL add_bcd latency: got %0d want 3", lat); end
    vecs++; if (out8 !== 8'h05) begin errs++; $display("FAIL add_bcd out: got %h want 05", out8); end
    vecs++; if (flags8 !== 5'b11001) begin errs++; $display("FAIL add_bcd flags: got %b want 11001", flags8); end
  endtask

  task automatic test_sub_cmp();
    int lat;
    tick();
    launch8(4'b0001, 1'b1, 8'h12, 8'h21, 1'b1);
    wait8(lat);
    vecs++; if (out8 !== 8'h91) begin errs++; $display("FAIL sub_bcd out: got %h want 91", out8); end
    vecs++; if (flags8 !== 5'b00101) begin errs++; $display("FAIL sub_bcd flags: got %b want 00101", flags8); end
    // ci=0 on purpose: CMP must force it to 1
    launch8(4'b1010, 1'b1, 8'h10, 8'h10, 1'b0);
    wait8(lat);
    vecs++; if (lat !== 3) begin errs++; $display("FAIL cmp latency: got %0d want 3", lat); end
    vecs++; if (out8 !== 8'h10) begin errs++; $display("FAIL cmp out: got %h want 10", out8); end
    vecs++; if (flags8 !== 5'b10011) begin errs++; $display("FAIL cmp flags: got %b want 10011", flags8); end
  endtask

  task automatic test_wide16();
    int lat;
    launch16(4'b0000, 1'b1, 16'h9999, 16'h0001, 1'b0);
    wait16(lat);
    vecs++; if (lat !== 5) begin errs++; $display("FAIL w16_bcd latency: got %0d want 5", lat); end
    vecs++; if (out16 !== 16'h0000) begin errs++; $display("FAIL w16_bcd out: got %h want 0000", out16); end
    vecs++; if (flags16 !== 5'b10011) begin errs++; $display("FAIL w16_bcd flags: got %b want 10011", flags16); end
    tick();
    launch16(4'b0000, 1'b0, 16'h1234, 16'h0FCC, 1'b0);
    wait16(lat);
    vecs++; if (out16 !== 16'h2200) begin errs++; $display("FAIL w16_bin out: got %h want 2200", out16); end
    vecs++; if (flags16 !== 5'b00001) begin errs++; $display("FAIL w16_bin flags: got %b want 00001", flags16); end
  endtask

  task automatic test_back_to_back();
    int lat;
    tick();
    launch8(4'b0101, 1'b0, 8'h01, 8'h00, 1'b1);
    wait8(lat);
    vecs++; if (lat !== 1) begin errs++; $display("FAIL ror latency: got %0d want 1", lat); end
    vecs++; if ({out8, flags8} !== {8'h80, 5'b10100}) begin errs++; $display("FAIL ror result: got %h %b want 80 10100", out8, flags8); end
    // Start issued in the done cycle
    launch8(4'b0010, 1'b0, 8'h81, 8'h00, 1'b0);
    vecs++; if (busy8 !== 1'b1) begin errs++; $display("FAIL b2b accept: busy got %b want 1", busy8); end
    wait8(lat);
    vecs++; if (lat !== 1) begin errs++; $display("FAIL asl latency: got %0d want 1", lat); end
    vecs++; if ({out8, flags8} !== {8'h02, 5'b10000}) begin errs++; $display("FAIL asl result: got %h %b want 02 10000", out8, flags8); end
  endtask

  task automatic test_logic_shift();
    logic [3:0] t_op   [6] = '{4'b0110, 4'b1000, 4'b0111, 4'b0011, 4'b0100, 4'b1111};
    logic [7:0] t_a    [6] = '{8'hF0, 8'hAA, 8'h3C, 8'h80, 8'h01, 8'h5A};
    logic [7:0] t_b    [6] = '{8'h0F, 8'hAA, 8'h0F, 8'hFF, 8'hFF, 8'h00};
    logic       t_ci   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] t_out  [6] = '{8'hFF, 8'h00, 8'h0C, 8'h01, 8'h00, 8'h5A};
    logic [4:0] t_flg  [6] = '{5'b00100, 5'b00010, 5'b00000, 5'b10000, 5'b10010, 5'b00000};
    int lat;
    for (int i = 0; i < 6; i++) begin
      launch8(t_op[i], 1'b1, t_a[i], t_b[i], t_ci[i]);
      wait8(lat);
      vecs++; if ({out8, flags8} !== {t_out[i], t_flg[i]}) begin
        errs++; $display("FAIL logic_shift[%0d] op %b: got %h %b want %h %b", i, t_op[i], out8, flags8, t_out[i], t_flg[i]); end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    tick();
    launch8(4'b0000, 1'b0, 8'h11, 8'h22, 1'b0);
    op8 = 4'b1000; ai8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait8(lat);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL busy_ignore latency: got %0d want 2", lat); end
    vecs++; if (out8 !== 8'h33) begin errs++; $display("FAIL busy_ignore out: got %h want 33", out8); end
    tick();
    vecs++; if ({busy8, done8} !== 2'b00) begin errs++; $display("FAIL busy_ignore queued: got %b want 00", {busy8, done8}); end
  endtask

  task automatic test_stall();
    int lat;
    launch8(4'b0000, 1'b0, 8'h25, 8'h13, 1'b0);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++; if ({busy8, done8} !== 2'b10) begin errs++; $display("FAIL stall cycle %0d: got %b want 10", i, {busy8, done8}); end
    end
    rdy = 1'b1;
    wait8(lat);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL stall remaining edges: got %0d want 2", lat); end
    vecs++; if ({out8, flags8} !== {8'h38, 5'b00000}) begin errs++; $display("FAIL stall result: got %h %b want 38 00000", out8, flags8); end
    rdy = 1'b0;
    tick(); tick();
    vecs++; if ({done8, out8} !== {1'b1, 8'h38}) begin errs++; $display("FAIL stall done hold: got %b %h want 1 38", done8, out8); end
    rdy = 1'b1;
    tick();
    vecs++; if (done8 !== 1'b0) begin errs++; $display("FAIL stall done drop: got %b want 0", done8); end
  endtask

  task automatic test_reset_abort();
    launch8(4'b0000, 1'b0, 8'h7F, 8'h01, 1'b0);
    tick(); tick();
    #1 reset_n = 1'b0;
    #1;
    vecs++; if ({busy8, done8, out8, flags8} !== {2'b00, 8'h00, 5'b00010}) begin
      errs++; $display("FAIL reset_abort async: got %b %h %b want 00 00 00010", {busy8, done8}, out8, flags8); end
    #3 reset_n = 1'b1;
    tick(); tick();
    vecs++; if ({busy8, done8, out8} !== {2'b00, 8'h00}) begin
      errs++; $display("FAIL reset_abort after: got %b %h want 00 00", {busy8, done8}, out8); end
  endtask

  initial begin
    reset_n = 1'b0; rdy = 1'b1;
    start8 = 1'b0; op8 = '0; bcd8 = 1'b0; ai8 = '0; bi8 = '0; ci8 = 1'b0;
    start16 = 1'b0; op16 = '0; bcd16 = 1'b0; ai16 = '0; bi16 = '0; ci16 = 1'b0;
    test_reset();
    test_add_bin();
    test_add_bcd();
    test_sub_cmp();
    test_wide16();
    test_back_to_back();
    test_logic_shift();
    test_busy_ignore();
    test_stall();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
